// File: rtl/proto_pkg.sv
// proto_processor_mc shared definitions:
// FSM states, instruction fields, WS and ALU codes.
package proto_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_EXEC      = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  localparam int B_BIT    = 31;
  localparam int C_BIT    = 30;
  localparam int WE_BIT   = 29;
  localparam int WS_HI    = 28;
  localparam int WS_LO    = 27;
  localparam int OP_HI    = 26;
  localparam int OP_LO    = 23;
  localparam int RA1_HI   = 22;
  localparam int RA1_LO   = 18;
  localparam int RA2_HI   = 17;
  localparam int RA2_LO   = 13;
  localparam int WA_HI    = 12;
  localparam int WA_LO    = 8;
  localparam int CONST_HI = 7;
  localparam int CONST_LO = 0;

  localparam logic [1:0] WS_CONST = 2'b00;
  localparam logic [1:0] WS_SW    = 2'b01;
  localparam logic [1:0] WS_ALU   = 2'b10;
  localparam logic [1:0] WS_ZERO  = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LT   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/hex_decoder.sv
// Nibble to 7-segment, active-low, gfedcba.
module hex_decoder (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Segment lookup.
  always_comb begin
    seg_o = 7'h7f;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'ha: seg_o = 7'b0001000;
      4'hb: seg_o = 7'b0000011;
      4'hc: seg_o = 7'b1000110;
      4'hd: seg_o = 7'b0100001;
      4'he: seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/miriscv_alu.sv
// Integer ALU: arithmetic/logic result plus
// a comparison flag for conditional branches.
module miriscv_alu
  import proto_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output logic        flag_o
);

  // Compare ops also return the flag as result.
  always_comb begin
    res_o  = '0;
    flag_o = 1'b0;
    case (op_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_SLL:  res_o = a_i << b_i[4:0];
      ALU_SLT:  res_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: res_o = {31'd0, a_i < b_i};
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_SRL:  res_o = a_i >> b_i[4:0];
      ALU_SRA:  res_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_OR:   res_o = a_i | b_i;
      ALU_AND:  res_o = a_i & b_i;
      ALU_EQ:   flag_o = (a_i == b_i);
      ALU_NE:   flag_o = (a_i != b_i);
      ALU_LT:   flag_o = ($signed(a_i) < $signed(b_i));
      ALU_GE:   flag_o = ($signed(a_i) >= $signed(b_i));
      ALU_LTU:  flag_o = (a_i < b_i);
      ALU_GEU:  flag_o = (a_i >= b_i);
      default:  res_o = '0;
    endcase
    if (op_i >= ALU_EQ) res_o = {31'd0, flag_o};
  end

endmodule

// File: rtl/proto_rf_param.sv
// NUM_REGS x 32 register file, sync reset;
// out-of-range reads give 0, writes dropped.
module proto_rf_param #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0] mem_q [NUM_REGS];

  // Clear on reset, single write port otherwise.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i && (int'(wa_i) < NUM_REGS)) begin
      mem_q[wa_i[AW-1:0]] <= wd_i;
    end
  end

  assign rd1_o = (int'(ra1_i) < NUM_REGS) ? mem_q[ra1_i[AW-1:0]] : '0;
  assign rd2_o = (int'(ra2_i) < NUM_REGS) ? mem_q[ra2_i[AW-1:0]] : '0;

endmodule

// File: rtl/proto_processor_mc.sv
// Multi-cycle prototype core: handshake fetch,
// one-cycle exec, halt, single-step, retire count.
module proto_processor_mc
  import proto_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h7600_0000,
  parameter int          SW_WIDTH = 10,
  parameter int          NUM_REGS = 32
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches_i,
  output logic                imem_req_o,
  output logic [31:0]         imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [31:0]         imem_rdata_i,
  input  logic                step_en_i,
  input  logic                step_i,
  output logic                halted_o,
  output logic [31:0]         pc_o,
  output logic [31:0]         result_o,
  output logic [31:0]         retired_o,
  output logic [6:0]          hex1_o,
  output logic [6:0]          hex2_o
);

  state_e      state_q;
  logic [31:0] pc_q, ir_q, result_q, retired_q;

  logic [31:0] se, sw_ext, rd1, rd2, alu_res, wd, pc_d;
  logic        flag, rf_we, halt_now;

  assign se     = {{24{ir_q[CONST_HI]}}, ir_q[CONST_HI:CONST_LO]};
  assign sw_ext = 32'($signed(switches_i));

  miriscv_alu u_alu (
    .op_i   (ir_q[OP_HI:OP_LO]),
    .a_i    (rd1),
    .b_i    (rd2),
    .res_o  (alu_res),
    .flag_o (flag)
  );

  assign rf_we = (state_q == S_EXEC) && ir_q[WE_BIT];

  proto_rf_param #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk_i (clk_i),
    .reset (reset),
    .we_i  (rf_we),
    .wa_i  (ir_q[WA_HI:WA_LO]),
    .wd_i  (wd),
    .ra1_i (ir_q[RA1_HI:RA1_LO]),
    .ra2_i (ir_q[RA2_HI:RA2_LO]),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  // Write-data select and next-PC.
  always_comb begin
    wd = '0;
    case (ir_q[WS_HI:WS_LO])
      WS_CONST: wd = se;
      WS_SW:    wd = sw_ext;
      WS_ALU:   wd = alu_res;
      default:  wd = '0;
    endcase
    if (ir_q[B_BIT] || (ir_q[C_BIT] && flag))
      pc_d = pc_q + (se << 2);
    else
      pc_d = pc_q + 32'd4;
    halt_now = ir_q[B_BIT] && (ir_q[CONST_HI:CONST_LO] == 8'd0);
  end

  // Control FSM with PC, IR, result and retire count.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      result_q  <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ack_i) begin
            ir_q    <= imem_rdata_i;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc_q      <= pc_d;
          retired_q <= retired_q + 32'd1;
          if (ir_q[WE_BIT]) result_q <= wd;
          if (halt_now)       state_q <= S_HALT;
          else if (step_en_i) state_q <= S_STEP_WAIT;
          else                state_q <= S_FETCH;
        end
        S_STEP_WAIT: begin
          if (step_i || !step_en_i) state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign halted_o    = (state_q == S_HALT);
  assign pc_o        = pc_q;
  assign result_o    = result_q;
  assign retired_o   = retired_q;

  hex_decoder u_hex1 (.nib_i(result_q[3:0]), .seg_o(hex1_o));
  hex_decoder u_hex2 (.nib_i(result_q[7:4]), .seg_o(hex2_o));

endmodule

// File: tb/tb_proto_processor_mc.sv
// Randomised bench for proto_processor_mc
// against an instruction-level reference model.
module tb_proto_processor_mc;

  localparam logic [31:0] RST_PC = 32'h7600_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  switches_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        step_en_i = 1'b0;
  logic        step_i = 1'b0;
  logic        halted_o;
  logic [31:0] pc_o, result_o, retired_o;
  logic [6:0]  hex1_o, hex2_o;

  proto_processor_mc dut (
    .clk_i        (clk),
    .reset        (reset),
    .switches_i   (switches_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .step_en_i    (step_en_i),
    .step_i       (step_i),
    .halted_o     (halted_o),
    .pc_o         (pc_o),
    .result_o     (result_o),
    .retired_o    (retired_o),
    .hex1_o       (hex1_o),
    .hex2_o       (hex2_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_pc, m_res, m_ret;
  bit          m_halt;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0e};
    return t[n];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = RST_PC; m_res = '0; m_ret = '0; m_halt = 0;
  endfunction

  function automatic void m_exec(input logic [31:0] ins,
                                 input logic [9:0] sw);
    logic [31:0] a, b, alu, wd, se;
    longint sa, sb;
    bit f;
    a  = m_reg[ins[22:18]];
    b  = m_reg[ins[17:13]];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    se = 32'(longint'($signed(ins[7:0])));
    f  = 0;
    alu = '0;
    case (int'(ins[26:23]))
      0: alu = a + b;
      1: alu = a - b;
      2: alu = a << b[4:0];
      3: alu = (sa < sb) ? 1 : 0;
      4: alu = (a < b) ? 1 : 0;
      5: alu = a ^ b;
      6: alu = a >> b[4:0];
      7: alu = 32'(sa >>> b[4:0]);
      8: alu = a | b;
      9: alu = a & b;
      10: f = (a == b);
      11: f = (a != b);
      12: f = (sa < sb);
      13: f = (sa >= sb);
      14: f = (a < b);
      default: f = (a >= b);
    endcase
    if (ins[26:23] >= 10) alu = f ? 1 : 0;
    case (ins[28:27])
      2'b00: wd = se;
      2'b01: wd = 32'(longint'($signed(sw)));
      2'b10: wd = alu;
      default: wd = 0;
    endcase
    if (ins[29]) begin
      m_reg[ins[12:8]] = wd;
      m_res = wd;
    end
    if (ins[31] || (ins[30] && f)) m_pc = m_pc + se * 4;
    else m_pc = m_pc + 4;
    m_ret = m_ret + 1;
    m_halt = ins[31] && (ins[7:0] == 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ack_i = 0; step_i = 0; step_en_i = 0;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_ret", retired_o, 0);
    chk("rst_res", result_o, 0);
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_halt", 32'(halted_o), 0);
    reset = 1'b0;
  endtask

  // One fetch/execute, with the after-exec check.
  task automatic run_instr(input logic [31:0] ins,
                           input int wt,
                           input logic [9:0] sw,
                           input bit sten,
                           input bit pulse);
    int n = 0;
    while (!imem_req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req_o) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("fetch_addr", imem_addr_o, m_pc);
    step_en_i = sten;
    for (int i = 0; i < wt; i++) begin
      step_i = pulse && (i == 0);
      @(negedge clk);
      step_i = 1'b0;
    end
    if (wt > 0) chk("req_held", 32'(imem_req_o), 1);
    imem_ack_i = 1'b1;
    imem_rdata_i = ins;
    @(negedge clk);
    imem_ack_i = 1'b0;
    imem_rdata_i = $urandom;
    switches_i = sw;
    @(negedge clk);
    m_exec(ins, sw);
    chk("pc", pc_o, m_pc);
    chk("result", result_o, m_res);
    chk("retired", retired_o, m_ret);
    chk("halted", 32'(halted_o), 32'(m_halt));
    chk("hex1", 32'(hex1_o), 32'(seg(m_res[3:0])));
    chk("hex2", 32'(hex2_o), 32'(seg(m_res[7:4])));
  endtask

  // Hold in STEP_WAIT, then release by pulse or by
  // dropping step mode.
  task automatic step_release(input bit by_pulse);
    for (int i = 0; i < 2; i++) begin
      chk("sw_noreq", 32'(imem_req_o), 0);
      chk("sw_ret", retired_o, m_ret);
      @(negedge clk);
    end
    if (by_pulse) step_i = 1'b1;
    else step_en_i = 1'b0;
    @(negedge clk);
    step_i = 1'b0;
    chk("sw_go", 32'(imem_req_o), 1);
  endtask

  initial begin
    logic [31:0] ins, p0;
    bit sten;

    do_reset();

    // First fetch with 3 wait cycles
    run_instr(32'h2000_0005, 3, 10'h0, 0, 0);
    chk("hex1_5", 32'(hex1_o), 32'h12);
    chk("pc_first", pc_o, 32'h7600_0004);

    // Switches into r1, then r1+r1 into r2
    run_instr(32'h2800_0100, 0, 10'h3ff, 0, 0);
    chk("sw_ext", result_o, 32'hffff_ffff);
    run_instr(32'h3004_2200, 1, 10'h0, 0, 0);
    chk("add", result_o, 32'hffff_fffe);

    // Branches
    p0 = m_pc;
    run_instr(32'h8000_00fe, 0, 10'h0, 0, 0);
    chk("b_back", pc_o, p0 - 8);
    p0 = m_pc;
    run_instr(32'h4504_4004, 0, 10'h0, 0, 0);
    chk("c_false", pc_o, p0 + 4);
    p0 = m_pc;
    run_instr(32'h4504_2004, 2, 10'h0, 0, 0);
    chk("c_true", pc_o, p0 + 16);
    p0 = m_pc;
    run_instr(32'hc000_0003, 0, 10'h0, 0, 0);
    chk("bc_pri", pc_o, p0 + 12);

    // Single step: early pulse dropped, then release
    run_instr(32'h2000_0107, 2, 10'h0, 1, 1);
    step_release(1);
    run_instr(32'h2000_0209, 0, 10'h0, 1, 0);
    step_release(0);

    // Random instructions, latencies, step mode
    for (int k = 0; k < 300; k++) begin
      ins = $urandom;
      if (ins[31] && ins[7:0] == 0) ins[0] = 1'b1;
      sten = ($urandom_range(0, 4) == 0);
      run_instr(ins, $urandom_range(0, 3),
                10'($urandom), sten,
                sten && ($urandom_range(0, 1) == 1));
      if (sten) step_release($urandom_range(0, 1) == 1);
    end

    // Halt with a write of 0 to r0
    run_instr(32'h2000_0033, 0, 10'h0, 0, 0);
    p0 = m_pc;
    run_instr(32'ha000_0000, 0, 10'h0, 0, 0);
    chk("halt_pc", pc_o, p0);
    chk("halt_res", result_o, 0);
    for (int i = 0; i < 4; i++) begin
      step_i = 1'b1;
      imem_ack_i = 1'b1;
      @(negedge clk);
      chk("halt_noreq", 32'(imem_req_o), 0);
      chk("halt_hold", 32'(halted_o), 1);
      chk("halt_ret", retired_o, m_ret);
    end
    step_i = 1'b0;
    imem_ack_i = 1'b0;
    do_reset();
    chk("post_halt_pc", pc_o, RST_PC);

    // Reset mid-fetch, then a late ack
    run_instr(32'h2000_0011, 0, 10'h0, 0, 0);
    @(negedge clk);
    chk("mf_req", 32'(imem_req_o), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'h2000_0077;
    @(negedge clk);
    imem_ack_i = 1'b0;
    chk("mf_req2", 32'(imem_req_o), 1);
    chk("mf_addr", imem_addr_o, RST_PC);
    chk("mf_ret", retired_o, 0);
    chk("mf_res", result_o, 0);
    run_instr(32'h3000_0300, 1, 10'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/proto_processor_mc.md
# proto_processor_mc

Multi-cycle, parametrised successor to the single-cycle prototype core: it executes the same 32-bit B/C/WE/WS/ALUop/RA1/RA2/WA/CONST instruction format. It fetches over a variable-latency instruction-memory handshake and adds a halt instruction, a single-step debug mode and a retired-instruction counter. It sits between the board switches and hex displays and an external instruction memory.

## Interface
- `RESET_PC`, 32'h7600_0000, PC value after reset.
- `SW_WIDTH`, 10, width of `switches_i`; 1..32.
- `NUM_REGS`, 32, implemented registers; 2..32.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `switches_i`  in  SW_WIDTH  switch data, sampled in EXEC.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address (= PC).
- `imem_ack_i`  in  1  fetch data valid.
- `imem_rdata_i`  in  32  fetched instruction.
- `step_en_i`  in  1  single-step mode enable.
- `step_i`  in  1  one-cycle pulse that releases one instruction in step mode.
- `halted_o`  out  1  core is in HALT.
- `pc_o`  out  32  current PC.
- `result_o`  out  32  last value written to the register file.
- `retired_o`  out  32  count of executed instructions.
- `hex1_o`, `hex2_o`  out  7 each  segments for `result_o[3:0]` and `result_o[7:4]`.

## Operation
- States: IDLE, FETCH, EXEC, STEP_WAIT, HALT. Encoding is 3 bits.
- IDLE always moves to FETCH on the next clock.
- FETCH:
  - `imem_req_o`=1 and `imem_addr_o`=PC, held stable until ack.
  - On `imem_ack_i`=1, latch `imem_rdata_i` into IR and go to EXEC.
  - Ack outside FETCH is ignored.
- EXEC occupies exactly one cycle and performs all of the following:
  - Read RA1/RA2 and apply ALUop via `miriscv_alu`.
  - Compute `se` = sign-extended CONST[7:0].
  - Write-data select (WS): 00 → `se`; 01 → `switches_i` sign-extended from bit SW_WIDTH-1; 10 → ALU result; 11 → 0.
  - If WE=1, write `wd` to WA and copy `wd` to `result_o`. This is exactly one write per instruction.
  - Next PC:
    - B=1 → PC+(`se`<<2).
    - Otherwise C=1 with comparison=1 → PC+(`se`<<2).
    - Otherwise → PC+4.
    - Arithmetic is modulo 2^32. B has priority over C.
  - `retired_o` increments and wraps from 0xFFFF_FFFF to 0.
  - Halt condition is B=1 with CONST=0.
    - The instruction still completes: PC is unchanged and any write happens.
    - Next state is HALT.
  - Otherwise, next state is STEP_WAIT if `step_en_i`=1, else FETCH.
- STEP_WAIT:
  - Go to FETCH in the cycle `step_i`=1, or immediately if `step_en_i` drops to 0.
- HALT:
  - Terminal until reset; `halted_o`=1.
  - `step_i` and `imem_ack_i` are ignored.
- Register file:
  - NUM_REGS × 32 bits; all registers are writable, including register 0.
  - Address ≥ NUM_REGS reads as 0 and the write is dropped.
- Reset (any state, including mid-fetch):
  - state=IDLE, PC=RESET_PC.
  - IR, all registers, `result_o` and `retired_o` are set to 0.
  - `imem_req_o`=0 and `halted_o`=0 from the following cycle.
  - An outstanding ack arriving after reset is ignored, because the state is no longer FETCH.

## Timing
- `imem_req_o`, `halted_o` and `imem_addr_o` are decoded from registered state and PC, with no combinational path from inputs.
- A zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction. Each wait cycle adds 1.
- Register writes, PC, `result_o` and `retired_o` update on the clock edge that ends EXEC. The hex outputs follow `result_o` combinationally.
- An instruction reads register values written by the previous instruction; no hazards exist.
- A `step_i` pulse arriving while the core is not in STEP_WAIT is dropped.

## Structure
- Package `proto_pkg` holds:
  - the state enum;
  - field position constants (B=31, C=30, WE=29, WS=28:27, ALUop=26:23, RA1=22:18, RA2=17:13, WA=12:8, CONST=7:0);
  - the WS encodings.
- Reused sub-modules: `miriscv_alu` and two `hex_decoder` instances.
- New sub-module: `proto_rf_param`, holding the NUM_REGS register file with synchronous reset and out-of-range masking.

## Test plan
- **Reset and first fetch:** release reset, ack after 3 cycles with 0x2000_0005 (WE, WS=00, WA=0, CONST=5) → `imem_addr_o`=0x7600_0000, `result_o`=5, `retired_o`=1, PC=0x7600_0004, hex1 shows 5.
- **Switches and ALU:** WS=01 with `switches_i`=0x3FF into r1 → `result_o`=0xFFFF_FFFF. Then add r1+r1 into r2 → `result_o`=0xFFFF_FFFE.
- **Branches:**
  - B=1, CONST=0xFE at PC 0x100 → next fetch at 0xF8.
  - C=1 with comparison false → next fetch at PC+4.
  - B=1 and C=1 together → B target taken.
- **Halt:** B=1, CONST=0 → `halted_o`=1, no further `imem_req_o`, PC unchanged; `step_i` pulses have no effect; reset restores RESET_PC.
- **Single step:** `step_en_i`=1 → exactly one instruction retired per `step_i` pulse; a pulse during FETCH is dropped; clearing `step_en_i` resumes free run.
- **Reset mid-fetch:** assert reset while `imem_req_o`=1, then send a late ack → ack ignored, IR=0, fetch restarts at RESET_PC with `retired_o`=0.
